mux_4to1: RTL and testbench
===========================

MUX_4TO1 -- requirements
Module: mux_4to1

Interface
REQ-001 Parameter WIDTH, default 8: bit width of each data input and of o_data.
REQ-002 Parameter SCAN_DIV, default 4: clock cycles per selection step in auto-scan mode; legal range 1..65535.
REQ-003 i_clk  input  1  single clock; all state updates on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-low; sampled only on the rising edge of i_clk.
REQ-005 i_data_0  input  WIDTH  data channel 0.
REQ-006 i_data_1  input  WIDTH  data channel 1.
REQ-007 i_data_2  input  WIDTH  data channel 2.
REQ-008 i_data_3  input  WIDTH  data channel 3.
REQ-009 i_ctrl  input  2  channel select: 00 -> ch0, 01 -> ch1, 10 -> ch2, 11 -> ch3.
REQ-010 o_data  output  WIDTH  registered selected channel data.
REQ-011 o_sel  output  2  registered index of the channel currently driven on o_data.

Function
REQ-012 On each rising edge with i_rst high, the block SHALL load o_data with the channel chosen by the active select, and o_sel with that channel index.
REQ-013 Latency SHALL be exactly one clock: a change in i_ctrl or in the selected i_data_n before edge k SHALL appear on o_data after edge k.
REQ-014 Between rising edges, o_data and o_sel SHALL hold their values; there is no combinational path from any input to any output.
REQ-015 All four i_ctrl codes are legal; no code SHALL produce X or hold the previous value.
REQ-016 Changes on non-selected channels SHALL NOT affect o_data.
REQ-017 If i_ctrl and the data inputs change before the same edge, o_data SHALL take the new data of the newly selected channel.

Reset
REQ-018 While i_rst is low at a rising edge, o_data SHALL become all zeros and o_sel SHALL become 00.
REQ-019 The auto-scan counter and scan index SHALL clear to zero on the same edge.
REQ-020 Input values present during reset SHALL be ignored.
REQ-021 On the first edge with i_rst high, the block SHALL perform a normal selection.
REQ-022 Reset asserted mid-operation SHALL override any selection on that edge.
REQ-023 Reset SHALL have no asynchronous effect: outputs SHALL NOT change before the next rising edge.

Configuration
REQ-024 Macro MUX_AUTOSCAN_EN, when defined, SHALL replace i_ctrl with an internal 2-bit scan index as the active select; i_ctrl is then ignored.
REQ-025 With MUX_AUTOSCAN_EN defined, an internal counter SHALL count 0..SCAN_DIV-1.
REQ-026 With MUX_AUTOSCAN_EN defined, the scan index SHALL advance when the counter wraps, in the sequence 0,1,2,3,0.
REQ-027 With MUX_AUTOSCAN_EN defined, each channel SHALL be shown for exactly SCAN_DIV cycles.
REQ-028 With MUX_AUTOSCAN_EN defined and SCAN_DIV=1, the scan index SHALL advance every cycle.
REQ-029 Without MUX_AUTOSCAN_EN, i_ctrl SHALL be the sole select, no scan logic SHALL be synthesized, and the port list SHALL be unchanged.

Verification
REQ-030 Reset: i_rst=0 for 3 edges with data 1,2,3,4 -> o_data=0x00 and o_sel=00 throughout.
REQ-031 Release reset with i_ctrl=00 and data 1,2,3,4 -> o_data=0x01 one edge later.
REQ-032 Step i_ctrl through 00,01,10,11, one code per 2 cycles, with data 1,2,3,4 -> o_data=1,2,3,4 in turn, each lagging its i_ctrl change by one edge, and o_sel matching.
REQ-033 Hold i_ctrl=10 and change i_data_0 to 0xFF -> o_data stays 0x03; then change i_data_2 to 0xA5 -> o_data=0xA5 after the next edge.
REQ-034 Pulse i_rst low for one edge while o_data=0x04 -> o_data=0x00 for that edge, then the selected value resumes.
REQ-035 With MUX_AUTOSCAN_EN defined, SCAN_DIV=2, data 1,2,3,4 and i_ctrl held at 11 -> o_data sequence 1,1,2,2,3,3,4,4,1 after reset release.

Source files
------------

// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
// Module   : mux_4to1
// Brief    : Registered 4-to-1 multiplexer with one-clock latency. Defining
//            MUX_AUTOSCAN_EN replaces i_ctrl with an internal scan index that
//            steps through channels 0..3, holding each for SCAN_DIV cycles.
// Revision : 1.0 - initial release
// ============================================================================
module mux_4to1 #(
    parameter int WIDTH    = 8,
    parameter int SCAN_DIV = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data_0,
    input  logic [WIDTH-1:0] i_data_1,
    input  logic [WIDTH-1:0] i_data_2,
    input  logic [WIDTH-1:0] i_data_3,
    input  logic [1:0]       i_ctrl,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_sel
);

    logic [1:0]       w_sel;
    logic [WIDTH-1:0] w_data;

`ifdef MUX_AUTOSCAN_EN
    localparam logic [15:0] c_div_max = 16'(SCAN_DIV - 1);

    logic [15:0] r_scan_cnt;
    logic [1:0]  r_scan_idx;

    // The index advances on the wrap edge, so each channel is shown SCAN_DIV cycles.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_scan_cnt <= 16'd0;
            r_scan_idx <= 2'd0;
        end else if (r_scan_cnt == c_div_max) begin
            r_scan_cnt <= 16'd0;
            r_scan_idx <= r_scan_idx + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 16'd1;
        end
    end

    assign w_sel = r_scan_idx;
`else
    assign w_sel = i_ctrl;
`endif

    always_comb begin
        w_data = i_data_0;
        case (w_sel)
            2'b00:   w_data = i_data_0;
            2'b01:   w_data = i_data_1;
            2'b10:   w_data = i_data_2;
            default: w_data = i_data_3;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            o_data <= '0;
            o_sel  <= 2'b00;
        end else begin
            o_data <= w_data;
            o_sel  <= w_sel;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mux_4to1.sv
`default_nettype none
// ============================================================================
// Module   : tb_mux_4to1
// Brief    : Scoreboard bench for mux_4to1; expected outputs are queued when
//            stimulus is applied and compared one edge later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mux_4to1;

    localparam int WIDTH    = 8;
    localparam int SCAN_DIV = 2;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [1:0]       sel;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] data_0, data_1, data_2, data_3;
    logic [1:0]       ctrl;
    logic [WIDTH-1:0] o_data;
    logic [1:0]       o_sel;

    exp_t q_exp[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   m_cnt    = 0;
    int   m_idx    = 0;

    mux_4to1 #(.WIDTH(WIDTH), .SCAN_DIV(SCAN_DIV)) dut (
        .i_clk    (clk),
        .i_rst    (rst),
        .i_data_0 (data_0),
        .i_data_1 (data_1),
        .i_data_2 (data_2),
        .i_data_3 (data_3),
        .i_ctrl   (ctrl),
        .o_data   (o_data),
        .o_sel    (o_sel)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [WIDTH-1:0] pick(input logic [1:0] s);
        case (s)
            2'd0:    return data_0;
            2'd1:    return data_1;
            2'd2:    return data_2;
            default: return data_3;
        endcase
    endfunction

    // Apply current inputs for one edge and compare the registered result.
    task automatic cycle(input string tag);
        exp_t e;
        logic [1:0] s;
        if (!rst) begin
            e.data = '0;
            e.sel  = 2'b00;
            m_cnt  = 0;
            m_idx  = 0;
        end else begin
`ifdef MUX_AUTOSCAN_EN
            s = 2'(m_idx);
            if (m_cnt == SCAN_DIV - 1) begin
                m_cnt = 0;
                m_idx = (m_idx + 1) % 4;
            end else begin
                m_cnt++;
            end
`else
            s = ctrl;
`endif
            e.data = pick(s);
            e.sel  = s;
        end
        q_exp.push_back(e);
        @(posedge clk);
        #1;
        e = q_exp.pop_front();
        check({tag, "_data"}, 32'(o_data), 32'(e.data));
        check({tag, "_sel"},  32'(o_sel),  32'(e.sel));
    endtask

    initial begin
        rst    = 1'b0;
        ctrl   = 2'b11;
        data_0 = 8'd1;
        data_1 = 8'd2;
        data_2 = 8'd3;
        data_3 = 8'd4;
        #1;
        for (int i = 0; i < 3; i++) cycle("reset");

        rst  = 1'b1;
        ctrl = 2'b00;
`ifdef MUX_AUTOSCAN_EN
        ctrl = 2'b11;
        for (int i = 0; i < 9; i++) cycle("scan");
        check("scan_end_data", 32'(o_data), 32'd1);
        for (int i = 0; i < 10; i++) begin
            ctrl   = 2'($urandom_range(0, 3));
            data_1 = 8'($urandom);
            cycle("scan_rand");
        end
`else
        cycle("release");
        check("release_value", 32'(o_data), 32'h01);

        for (int c = 0; c < 4; c++) begin
            ctrl = 2'(c);
            cycle("step_a");
            cycle("step_b");
        end

        ctrl   = 2'b10;
        data_0 = 8'hFF;
        cycle("unsel_change");
        check("unsel_hold", 32'(o_data), 32'h03);
        data_2 = 8'hA5;
        cycle("sel_change");
        data_2 = 8'd3;

        ctrl = 2'b11;
        cycle("pre_pulse");
        rst = 1'b0;
        #2;
        check("no_async_reset", 32'(o_data), 32'h04);
        cycle("pulse");
        rst = 1'b1;
        cycle("resume");

        for (int i = 0; i < 24; i++) begin
            ctrl   = 2'($urandom_range(0, 3));
            data_0 = 8'($urandom);
            data_1 = 8'($urandom);
            data_2 = 8'($urandom);
            data_3 = 8'($urandom);
            rst    = ($urandom_range(0, 7) != 0);
            cycle("random");
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
